// File: rtl/xps2_keydecoder.sv
// PS/2 set-2 key decoder: tracks make/break/extended prefixes and modifiers,
// translates make codes to characters and buffers them in a small FIFO.
module xps2_keydecoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic [8:0] kbd_in,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       caps_led
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_P   = ADDR_W'(1);

  state_t          state_q, state_d;
  logic            shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
  logic [8:0]      kbd_q;
  logic [7:0]      char_q, char_d;
  logic            char_vld_q, char_vld_d;
  logic [7:0]      code;
  logic            new_code;
  logic [8:0]      make_hit;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  assign code     = kbd_in[7:0];
  assign new_code = kbd_in[8] & (~kbd_q[8] | (code != kbd_q[7:0]));

  // Returns {hit, character} for a non-modifier make code.
  function automatic logic [8:0] map_make(input logic [7:0] sc, input logic upper,
                                          input logic ctl);
    logic [7:0] lc;
    logic [8:0] res;
    lc  = '0;
    res = '0;
    case (sc)
      8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
      8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
      8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
      8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
      default: lc = '0;
    endcase
    case (sc)
      8'h45: res = {1'b1, 8'h30};  8'h16: res = {1'b1, 8'h31};
      8'h1E: res = {1'b1, 8'h32};  8'h26: res = {1'b1, 8'h33};
      8'h25: res = {1'b1, 8'h34};  8'h2E: res = {1'b1, 8'h35};
      8'h36: res = {1'b1, 8'h36};  8'h3D: res = {1'b1, 8'h37};
      8'h3E: res = {1'b1, 8'h38};  8'h46: res = {1'b1, 8'h39};
      8'h29: res = {1'b1, 8'h20};  8'h5A: res = {1'b1, 8'h0D};
      8'h66: res = {1'b1, 8'h08};  8'h76: res = {1'b1, 8'h1B};
      default: res = '0;
    endcase
    if (lc != '0) begin
      if (ctl)        res = {1'b1, (lc - 8'h20) & 8'h1F};
      else if (upper) res = {1'b1, lc - 8'h20};
      else            res = {1'b1, lc};
    end
    return res;
  endfunction

  assign make_hit = map_make(code, shift_q ^ caps_q, ctrl_q);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    ctrl_d     = ctrl_q;
    caps_d     = caps_q;
    char_d     = '0;
    char_vld_d = 1'b0;
    if (new_code) begin
      // Prefix bytes restart the sequence from any state; only EXT turns F0 into EXT_BRK.
      if (code == 8'hF0) begin
        state_d = (state_q == EXT) ? EXT_BRK : BRK;
      end else if (code == 8'hE0) begin
        state_d = EXT;
      end else begin
        state_d = IDLE;
        case (state_q)
          IDLE: begin
            case (code)
              8'h12, 8'h59: shift_d = 1'b1;
              8'h14:        ctrl_d  = 1'b1;
              8'h58:        caps_d  = ~caps_q;
              default:      {char_vld_d, char_d} = make_hit;
            endcase
          end
          BRK: begin
            case (code)
              8'h12, 8'h59: shift_d = 1'b0;
              8'h14:        ctrl_d  = 1'b0;
              default:      ;
            endcase
          end
          EXT: begin
            case (code)
              8'h14:   ctrl_d = 1'b1;
              8'h75:   {char_vld_d, char_d} = {1'b1, 8'h80};
              8'h72:   {char_vld_d, char_d} = {1'b1, 8'h81};
              8'h6B:   {char_vld_d, char_d} = {1'b1, 8'h82};
              8'h74:   {char_vld_d, char_d} = {1'b1, 8'h83};
              default: ;
            endcase
          end
          EXT_BRK: begin
            if (code == 8'h14) ctrl_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pop      = sel & rd & (count_q != '0);
    push     = char_vld_q & ((count_q != DEPTH_C) | pop);
    wr_ptr_d = push ? wr_ptr_q + ONE_P : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ONE_P : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (char_vld_q & (count_q == DEPTH_C) & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= 1'b0;
      ctrl_q     <= 1'b0;
      caps_q     <= 1'b0;
      kbd_q      <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      ctrl_q     <= ctrl_d;
      caps_q     <= caps_d;
      kbd_q      <= kbd_in;
      char_q     <= char_d;
      char_vld_q <= char_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= char_q;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = ovf_q;
  assign caps_led = caps_q;

endmodule
